// File: rtl/abus_initiator_if.sv
// Signal bundle between the Avalon command side, the ABUS initiator and the external bus.
// The slave modport is the initiator's view; master is the environment driving it.
interface abus_initiator_if;
    logic [31:0] avs_addr;
    logic        avs_rd;
    logic        avs_wr;
    logic [15:0] avs_wdata;
    logic        avs_wait;
    logic [15:0] avs_rdata;
    logic        avs_rdvalid;
    logic [31:0] addr_out;
    logic        ale;
    logic        ncs;
    logic        nrd;
    logic        nwr;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in;
    logic        wait_in;
    logic        timeout_err;

    modport slave (
        input  avs_addr, avs_rd, avs_wr, avs_wdata, data_in, wait_in,
        output avs_wait, avs_rdata, avs_rdvalid, addr_out, ale, ncs, nrd, nwr,
               data_out, data_oe, timeout_err
    );

    modport master (
        output avs_addr, avs_rd, avs_wr, avs_wdata, data_in, wait_in,
        input  avs_wait, avs_rdata, avs_rdvalid, addr_out, ale, ncs, nrd, nwr,
               data_out, data_oe, timeout_err
    );
endinterface

// File: rtl/abus_initiator.sv
// Avalon-MM slave that runs single-word ABUS read/write cycles (ale, ncs, nrd, nwr)
// on the external connector, honouring the target's active-low wait line with a timeout.
module abus_initiator #(
    parameter int T_ALE    = 2,
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic              avm_clk,
    input  logic              avm_reset,
    abus_initiator_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        SETUP   = 3'd2,
        STROBE  = 3'd3,
        WAITCHK = 3'd4,
        HOLD    = 3'd5
    } state_t;

    localparam logic [15:0] ALE_LD    = 16'(T_ALE);
    localparam logic [15:0] SETUP_LD  = 16'(T_SETUP);
    localparam logic [15:0] STROBE_LD = 16'(T_STROBE);
    localparam logic [15:0] HOLD_LD   = 16'(T_HOLD);
    localparam logic [15:0] TO_LIM    = 16'(TIMEOUT);

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [15:0] tcnt_r, tcnt_s;
    logic        rd_op_r, rd_op_s;
    logic [1:0]  wait_sync_r;
    logic        wait_s;
    logic        ale_r, ale_s;
    logic        ncs_r, ncs_s;
    logic        nrd_r, nrd_s;
    logic        nwr_r, nwr_s;
    logic        data_oe_r, data_oe_s;
    logic [31:0] addr_r, addr_s;
    logic [15:0] data_r, data_s;
    logic [15:0] rdata_r, rdata_s;
    logic        rdvalid_r, rdvalid_s;
    logic        terr_r, terr_s;

    assign wait_s = wait_sync_r[1];

    // Two-flop synchronizer for the asynchronous target wait line (idles released)
    always_ff @(posedge avm_clk or posedge avm_reset) begin
        if (avm_reset) begin
            wait_sync_r <= 2'b11;
        end else begin
            wait_sync_r <= {wait_sync_r[0], bus.wait_in};
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead so every pin is a flop
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        tcnt_s    = tcnt_r;
        rd_op_s   = rd_op_r;
        ale_s     = ale_r;
        ncs_s     = ncs_r;
        nrd_s     = nrd_r;
        nwr_s     = nwr_r;
        data_oe_s = data_oe_r;
        addr_s    = addr_r;
        data_s    = data_r;
        rdata_s   = rdata_r;
        rdvalid_s = 1'b0;
        terr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // A simultaneous read and write is illegal; the read takes priority
                if (bus.avs_rd) begin
                    addr_s  = bus.avs_addr;
                    rd_op_s = 1'b1;
                    ale_s   = 1'b1;
                    cnt_s   = ALE_LD;
                    state_s = ADDR;
                end else if (bus.avs_wr) begin
                    addr_s  = bus.avs_addr;
                    data_s  = bus.avs_wdata;
                    rd_op_s = 1'b0;
                    ale_s   = 1'b1;
                    cnt_s   = ALE_LD;
                    state_s = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (cnt_r == 16'd1) begin
                    ale_s   = 1'b0;
                    cnt_s   = SETUP_LD;
                    state_s = SETUP;
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
            SETUP: begin
                if (cnt_r == 16'd1) begin
                    ncs_s     = 1'b0;
                    nrd_s     = ~rd_op_r;
                    nwr_s     = rd_op_r;
                    data_oe_s = ~rd_op_r;
                    cnt_s     = STROBE_LD;
                    state_s   = STROBE;
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
            STROBE: begin
                if (cnt_r == 16'd1) begin
                    tcnt_s  = 16'd0;
                    state_s = WAITCHK;
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
            WAITCHK: begin
                if (wait_s) begin
                    ncs_s     = 1'b1;
                    nrd_s     = 1'b1;
                    nwr_s     = 1'b1;
                    rdvalid_s = rd_op_r;
                    rdata_s   = rd_op_r ? bus.data_in : rdata_r;
                    cnt_s     = HOLD_LD;
                    state_s   = HOLD;
                end else if ((tcnt_r + 16'd1) == TO_LIM) begin
                    // Abort: reads complete with an all-ones word so the master never stalls
                    ncs_s     = 1'b1;
                    nrd_s     = 1'b1;
                    nwr_s     = 1'b1;
                    terr_s    = 1'b1;
                    rdvalid_s = rd_op_r;
                    rdata_s   = rd_op_r ? 16'hFFFF : rdata_r;
                    tcnt_s    = tcnt_r + 16'd1;
                    cnt_s     = HOLD_LD;
                    state_s   = HOLD;
                end else begin
                    tcnt_s = tcnt_r + 16'd1;
                end
            end
            HOLD: begin
                if (cnt_r == 16'd1) begin
                    data_oe_s = 1'b0;
                    state_s   = IDLE;
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
            default: begin
                ale_s     = 1'b0;
                ncs_s     = 1'b1;
                nrd_s     = 1'b1;
                nwr_s     = 1'b1;
                data_oe_s = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset releases strobes without a clock
    always_ff @(posedge avm_clk or posedge avm_reset) begin
        if (avm_reset) begin
            state_r   <= IDLE;
            cnt_r     <= 16'd0;
            tcnt_r    <= 16'd0;
            rd_op_r   <= 1'b0;
            ale_r     <= 1'b0;
            ncs_r     <= 1'b1;
            nrd_r     <= 1'b1;
            nwr_r     <= 1'b1;
            data_oe_r <= 1'b0;
            addr_r    <= 32'd0;
            data_r    <= 16'd0;
            rdata_r   <= 16'd0;
            rdvalid_r <= 1'b0;
            terr_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            tcnt_r    <= tcnt_s;
            rd_op_r   <= rd_op_s;
            ale_r     <= ale_s;
            ncs_r     <= ncs_s;
            nrd_r     <= nrd_s;
            nwr_r     <= nwr_s;
            data_oe_r <= data_oe_s;
            addr_r    <= addr_s;
            data_r    <= data_s;
            rdata_r   <= rdata_s;
            rdvalid_r <= rdvalid_s;
            terr_r    <= terr_s;
        end
    end

    assign bus.avs_wait    = avm_reset | (state_r != IDLE);
    assign bus.avs_rdata   = rdata_r;
    assign bus.avs_rdvalid = rdvalid_r;
    assign bus.addr_out    = addr_r;
    assign bus.ale         = ale_r;
    assign bus.ncs         = ncs_r;
    assign bus.nrd         = nrd_r;
    assign bus.nwr         = nwr_r;
    assign bus.data_out    = data_r;
    assign bus.data_oe     = data_oe_r;
    assign bus.timeout_err = terr_r;

endmodule

// File: doc/abus_initiator.md
Name: abus_initiator

Overview:
- Avalon-MM slave that turns single-word read/write commands into ABUS-style external bus cycles (ale, ncs, nrd, nwr, 32-bit address, 16-bit data) and honours the target's active-low wait line.
- It is the initiator counterpart to our ABUS-to-Avalon target bridge.
- It sits between the internal Avalon fabric and the external connector, and is used for loopback testing of the target bridge and for driving external ABUS peripherals.

Parameters:
T_ALE, 2, cycles ale held high with address valid (>=1)
T_SETUP, 1, cycles from ale fall to ncs fall (>=1)
T_STROBE, 4, minimum cycles ncs/strobe low before wait is checked (>=3, covers the 2-FF wait sync)
T_HOLD, 2, cycles after strobe release before a new command is accepted; write data is still driven (>=1)
TIMEOUT, 1023, maximum cycles spent in WAITCHK before abort (<=65535)

Ports:
avm_clk  in  1  clock
avm_reset  in  1  asynchronous, active-high reset
avs_addr  in  32  command address
avs_rd  in  1  read request
avs_wr  in  1  write request
avs_wdata  in  16  write data
avs_wait  out  1  Avalon waitrequest
avs_rdata  out  16  read data
avs_rdvalid  out  1  read data valid, one-cycle pulse
addr_out  out  32  external address
ale  out  1  address latch enable, active high
ncs  out  1  chip select, active low
nrd  out  1  read strobe, active low
nwr  out  1  write strobe, active low
data_out  out  16  external write data
data_oe  out  1  external data driver enable
data_in  in  16  external read data
wait_in  in  1  target wait, active low (0 = target busy)
timeout_err  out  1  one-cycle pulse when a cycle aborts on timeout

Behaviour:
- Reset (asynchronous, active-high on avm_reset; clock avm_clk). Values while in reset:
  - state=IDLE, ale=0, ncs=1, nrd=1, nwr=1, data_oe=0.
  - addr_out=0, data_out=0, avs_rdata=0, avs_rdvalid=0, timeout_err=0.
  - All counters 0; wait synchronizer flops = 1.
  - avs_wait=1 while avm_reset is high.
- Reset mid-cycle: strobes are released immediately (asynchronously), and no rdvalid is issued for the aborted read.
- wait_in passes through a 2-FF synchronizer; the synchronized value is called wait_s.
- avs_wait = 1 in every state except IDLE. Commands are accepted only in IDLE.
- All external outputs are registered. Every state counter loads at state entry and counts down to 1.
- IDLE:
  - If avs_rd: latch avs_addr into addr_out, set rd_op=1, go to ADDR.
  - Else if avs_wr: latch avs_addr into addr_out and avs_wdata into data_out, set rd_op=0, go to ADDR.
  - If avs_rd and avs_wr are both high, the read wins and the write is dropped. This is an illegal master behaviour.
- ADDR: ale=1 for T_ALE cycles, then go to SETUP.
- SETUP: ale=0 for T_SETUP cycles, then go to STROBE.
- STROBE:
  - ncs=0; nrd=0 if rd_op, else nwr=0 and data_oe=1.
  - Lasts T_STROBE cycles, then go to WAITCHK with the timeout counter cleared.
- WAITCHK: strobes stay asserted.
  - wait_s==1: if rd_op, capture data_in into avs_rdata and pulse avs_rdvalid on the next edge. Go to HOLD.
  - wait_s==0: increment the timeout counter. When it reaches TIMEOUT, pulse timeout_err; if rd_op, also set avs_rdata=16'hFFFF with an avs_rdvalid pulse. Go to HOLD.
- HOLD:
  - ncs=1, nrd=1, nwr=1.
  - data_oe stays 1 for writes throughout HOLD.
  - After T_HOLD cycles: data_oe=0, go to IDLE.
- Latency, counted from the accept edge to avs_rdvalid high:
  - Minimum read latency = T_ALE+T_SETUP+T_STROBE+1 = 8 cycles with defaults.
  - Back-to-back command spacing = T_ALE+T_SETUP+T_STROBE+1+T_HOLD+1 cycles minimum.
- Boundary cases:
  - addr_out is held stable from ADDR through HOLD.
  - wait_in pulsing high for fewer than 2 cycles during WAITCHK may be missed. This is allowed; the target must hold the release.
  - A wait_in release that arrives during STROBE is honoured on the first WAITCHK cycle.

Test Plan:
- Read, wait_in tied 1, data_in=16'hA55A, addr 32'h0200_1000 -> ale high 2 cycles; ncs/nrd low 5 cycles; avs_rdvalid 8 cycles after accept with avs_rdata=16'hA55A; addr_out=32'h0200_1000 throughout.
- Write 16'h1234 to 32'h0400_0002, wait_in low from ncs fall for 10 cycles -> nwr low until 2 cycles after wait_in rises; data_out=16'h1234; data_oe high from STROBE through HOLD; avs_wait high until IDLE.
- Read with wait_in stuck low, TIMEOUT=1023 -> timeout_err pulses once; avs_rdvalid with avs_rdata=16'hFFFF; strobes released; next command accepted.
- avs_rd and avs_wr high together -> exactly one read cycle; nwr never asserted.
- avm_reset asserted during STROBE of a read -> ncs/nrd go high without waiting for a clock edge; no avs_rdvalid; after release a new write completes normally.
- Two back-to-back reads held on the bus -> second is accepted only after HOLD; ncs high for at least T_HOLD+T_ALE+T_SETUP cycles between cycles.
